// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding selects
// and the decode-stage control bundle that travels down the pipe.
package pipeline_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hz_state_e;

   localparam logic [1:0] FWD_RD   = 2'b00;
   localparam logic [1:0] FWD_RESW = 2'b01;
   localparam logic [1:0] FWD_ALUM = 2'b10;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic pc_src;
      logic branch;
   } ctrl_t;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one E-stage source operand; the M-stage result
// takes priority over the W-stage result.
module forward_unit
   import pipeline_pkg::*;
(
   input  logic       match_m,
   input  logic       match_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output logic [1:0] fwd
);

   always_comb begin
      fwd = FWD_RD;
      if (match_m & reg_write_m)      fwd = FWD_ALUM;
      else if (match_w & reg_write_w) fwd = FWD_RESW;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: forwarding, load-use/branch/memory stalls and flushes, and
// the control chain D->E->M->W. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       match,
   input  logic             RegWriteD,
   input  logic             MemtoRegD,
   input  logic             PCSrcD,
   input  logic             BranchD,
   input  logic             CondExE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             RegWriteW,
   output logic             MemtoRegW,
   output logic             PCSrcW,
   output logic             BranchTakenE,
`ifdef HAZARD_PERF_CNT_EN
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt,
`endif
   output logic             MemErr
);

   localparam int NUM_OPS = 2;
   localparam int WCW     = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [WCW-1:0] LIMIT = WCW'(WAIT_LIMIT);

   hz_state_e      state, state_nxt;
   logic [WCW-1:0] wait_cnt;
   ctrl_t          ctrl_e;
   logic           reg_write_m, mem_to_reg_m, pc_src_m;
   logic           ldr_stall, pc_pend, mem_wait, err_st, hold, at_limit;
   logic [NUM_OPS-1:0][1:0] fwd;

   // Operand A uses match_1e_{m,w} (bits 3,1); operand B uses match_2e_{m,w} (bits 2,0).
   for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
      forward_unit u_fwd (
         .match_m     (match[3-g]),
         .match_w     (match[1-g]),
         .reg_write_m (reg_write_m),
         .reg_write_w (RegWriteW),
         .fwd         (fwd[g])
      );
   end
   assign ForwardAE = fwd[0];
   assign ForwardBE = fwd[1];

   // Ready releases the wait in the same cycle so a coincident load-use stall applies at once.
   assign ldr_stall = match[4] & ctrl_e.mem_to_reg & ctrl_e.reg_write;
   assign pc_pend   = PCSrcD | ctrl_e.pc_src | pc_src_m;
   assign mem_wait  = ((state == MEM_WAIT) | ((state == RUN) & MemReqM)) & ~MemReadyM;
   assign err_st    = (state == ERROR);
   assign hold      = mem_wait | err_st;
   assign at_limit  = (state == MEM_WAIT) & ~MemReadyM & (wait_cnt == LIMIT);

   assign BranchTakenE = ctrl_e.branch & CondExE;
   assign stallF       = ldr_stall | pc_pend | hold;
   assign stallD       = ldr_stall | hold;
   assign stallE       = hold;
   assign stallM       = hold;
   assign flushD       = (pc_pend | PCSrcW | BranchTakenE) & ~hold;
   assign flushE       = (ldr_stall | BranchTakenE) & ~hold;
   assign MemErr       = err_st | at_limit;

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (MemReqM & ~MemReadyM) state_nxt = MEM_WAIT;
         MEM_WAIT: if (MemReadyM)            state_nxt = RUN;
                   else if (at_limit)        state_nxt = ERROR;
         ERROR:    state_nxt = ERROR;
         default:  state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == RUN && state_nxt == MEM_WAIT)
            wait_cnt <= '0;
         else if (state == MEM_WAIT && wait_cnt != LIMIT)
            wait_cnt <= wait_cnt + WCW'(1);
      end
   end

   // While held, E/M keep their contents and W takes a bubble so a retired write never repeats.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_e       <= '0;
         reg_write_m  <= 1'b0;
         mem_to_reg_m <= 1'b0;
         pc_src_m     <= 1'b0;
         RegWriteW    <= 1'b0;
         MemtoRegW    <= 1'b0;
         PCSrcW       <= 1'b0;
      end else if (hold) begin
         RegWriteW    <= 1'b0;
         MemtoRegW    <= 1'b0;
         PCSrcW       <= 1'b0;
      end else begin
         ctrl_e       <= flushE ? '0 : ctrl_t'{RegWriteD, MemtoRegD, PCSrcD, BranchD};
         reg_write_m  <= ctrl_e.reg_write & CondExE;
         mem_to_reg_m <= ctrl_e.mem_to_reg;
         pc_src_m     <= ctrl_e.pc_src & CondExE;
         RegWriteW    <= reg_write_m;
         MemtoRegW    <= mem_to_reg_m;
         PCSrcW       <= pc_src_m;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         StallCnt <= '0;
         FlushCnt <= '0;
      end else begin
         if (stallD) StallCnt <= StallCnt + CNT_W'(1);
         if (flushE) FlushCnt <= FlushCnt + CNT_W'(1);
      end
   end
`else
   logic [CNT_W-1:0] perf_unused;
   assign perf_unused = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl; counter checks are active
// when HAZARD_PERF_CNT_EN is defined.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  match = '0;
   logic        RegWriteD = 0, MemtoRegD = 0, PCSrcD = 0, BranchD = 0;
   logic        CondExE = 0, MemReqM = 0, MemReadyM = 0;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        stallF, stallD, stallE, stallM, flushD, flushE;
   logic        RegWriteW, MemtoRegW, PCSrcW, BranchTakenE, MemErr;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] StallCnt, FlushCnt;
`endif

   pipeline_hazard_ctrl #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .match(match),
      .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD), .BranchD(BranchD),
      .CondExE(CondExE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE),
      .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE),
`ifdef HAZARD_PERF_CNT_EN
      .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
      .MemErr(MemErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [14:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   int unsigned m_stall  = 0;
   int unsigned m_flush  = 0;

   localparam logic [14:0] Z = '0;

   // Expected vector: {FwdA, FwdB, stall FDEM, flush DE, W {rw,mtr,pcs}, BranchTakenE, MemErr}
   function automatic logic [14:0] e(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [3:0] st, input logic [1:0] fl,
                                     input logic [2:0] w, input logic bt, input logic err);
      return {fa, fb, st, fl, w, bt, err};
   endfunction

   // d = {RegWriteD, MemtoRegD, PCSrcD, BranchD}
   task automatic step(input string tag, input logic [4:0] m, input logic [3:0] d,
                       input logic c, input logic mq, input logic mr, input logic [14:0] ex);
      exp_t        it;
      logic [14:0] obs;
      @(posedge clk); #1;
      match = m;
      {RegWriteD, MemtoRegD, PCSrcD, BranchD} = d;
      CondExE = c; MemReqM = mq; MemReadyM = mr;
      it.tag = tag; it.exp = ex;
      sb.push_back(it);
      #2;
      it  = sb.pop_front();
      obs = {ForwardAE, ForwardBE, stallF, stallD, stallE, stallM, flushD, flushE,
             RegWriteW, MemtoRegW, PCSrcW, BranchTakenE, MemErr};
      n_assert++;
      assert (obs === it.exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", it.tag, obs, it.exp);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_assert++;
      assert (StallCnt === m_stall) else begin
         n_fail++;
         $error("FAIL %s_stallcnt: observed %0d expected %0d", it.tag, StallCnt, m_stall);
      end
      n_assert++;
      assert (FlushCnt === m_flush) else begin
         n_fail++;
         $error("FAIL %s_flushcnt: observed %0d expected %0d", it.tag, FlushCnt, m_flush);
      end
`endif
      if (it.exp[9]) m_stall++;
      if (it.exp[5]) m_flush++;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      match = '0;
      {RegWriteD, MemtoRegD, PCSrcD, BranchD} = '0;
      CondExE = 0; MemReqM = 0; MemReadyM = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_stall = 0;
      m_flush = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      step("rst_idle",   5'b00000, 4'b0000, 0, 0, 0, Z);
      // forwarding
      step("rw_d",       5'b00000, 4'b1000, 0, 0, 0, Z);
      step("rw_e",       5'b00000, 4'b0000, 1, 0, 0, Z);
      step("fwd_a_alum", 5'b01000, 4'b0000, 0, 0, 0, e(2'b10, 2'b00, 4'b0000, 2'b00, 3'b000, 0, 0));
      step("fwd_b_resw", 5'b00001, 4'b0000, 0, 0, 0, e(2'b00, 2'b01, 4'b0000, 2'b00, 3'b100, 0, 0));
      step("rw_d2",      5'b00000, 4'b1000, 0, 0, 0, Z);
      step("rw_d3",      5'b00000, 4'b1000, 1, 0, 0, Z);
      step("rw_e3",      5'b00000, 4'b0000, 1, 0, 0, Z);
      step("fwd_prio",   5'b01111, 4'b0000, 0, 0, 0, e(2'b10, 2'b10, 4'b0000, 2'b00, 3'b100, 0, 0));
      step("fwd_a_resw", 5'b01010, 4'b0000, 0, 0, 0, e(2'b01, 2'b00, 4'b0000, 2'b00, 3'b100, 0, 0));
      // load-use, twice
      step("ldr_d",      5'b00000, 4'b1100, 0, 0, 0, Z);
      step("ldr_use",    5'b10000, 4'b0000, 0, 0, 0, e(2'b00, 2'b00, 4'b1100, 2'b01, 3'b000, 0, 0));
      step("ldr_rel",    5'b10000, 4'b0000, 0, 0, 0, Z);
      step("ldr_wb",     5'b00000, 4'b0000, 0, 0, 0, e(2'b00, 2'b00, 4'b0000, 2'b00, 3'b010, 0, 0));
      step("ldr2_d",     5'b00000, 4'b1100, 0, 0, 0, Z);
      step("ldr2_use",   5'b10000, 4'b0000, 0, 0, 0, e(2'b00, 2'b00, 4'b1100, 2'b01, 3'b000, 0, 0));
      step("ldr2_rel",   5'b00000, 4'b0000, 0, 0, 0, Z);
`ifdef HAZARD_PERF_CNT_EN
      n_assert++;
      assert (StallCnt === 32'd2) else begin
         n_fail++;
         $error("FAIL perf_stall2: observed %0d expected 2", StallCnt);
      end
      n_assert++;
      assert (FlushCnt === 32'd2) else begin
         n_fail++;
         $error("FAIL perf_flush2: observed %0d expected 2", FlushCnt);
      end
`endif
      step("ldr2_wb",    5'b00000, 4'b0000, 0, 0, 0, e(2'b00, 2'b00, 4'b0000, 2'b00, 3'b010, 0, 0));
      // taken branch; the following RegWrite instruction must become a bubble
      step("br_d",       5'b00000, 4'b0001, 0, 0, 0, Z);
      step("br_taken",   5'b00000, 4'b1000, 1, 0, 0, e(2'b00, 2'b00, 4'b0000, 2'b11, 3'b000, 1, 0));
      step("br_bubble",  5'b00000, 4'b0000, 1, 0, 0, Z);
      step("br_bub_fwd", 5'b01000, 4'b0000, 0, 0, 0, Z);
      // PC write walking down the pipe
      step("pc_d",       5'b00000, 4'b0010, 0, 0, 0, e(2'b00, 2'b00, 4'b1000, 2'b10, 3'b000, 0, 0));
      step("pc_e",       5'b00000, 4'b0000, 1, 0, 0, e(2'b00, 2'b00, 4'b1000, 2'b10, 3'b000, 0, 0));
      step("pc_m",       5'b00000, 4'b0000, 0, 0, 0, e(2'b00, 2'b00, 4'b1000, 2'b10, 3'b000, 0, 0));
      step("pc_w",       5'b00000, 4'b0000, 0, 0, 0, e(2'b00, 2'b00, 4'b0000, 2'b10, 3'b001, 0, 0));
      step("pc_done",    5'b00000, 4'b0000, 0, 0, 0, Z);
      // memory wait of three cycles with a write parked in M
      step("mw_rw_d",    5'b00000, 4'b1000, 0, 0, 0, Z);
      step("mw_rw_e",    5'b00000, 4'b0000, 1, 0, 0, Z);
      step("mw_1",       5'b00000, 4'b0000, 0, 1, 0, e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, 0));
      step("mw_2",       5'b00000, 4'b0000, 0, 1, 0, e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, 0));
      step("mw_3",       5'b00000, 4'b0000, 0, 1, 0, e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, 0));
      step("mw_rdy",     5'b00000, 4'b0000, 0, 1, 1, Z);
      step("mw_retire",  5'b00000, 4'b0000, 0, 0, 0, e(2'b00, 2'b00, 4'b0000, 2'b00, 3'b100, 0, 0));
      step("mw_norpt",   5'b00000, 4'b0000, 0, 0, 0, Z);
      // ready coincident with load-use
      step("ml_ldr_d",   5'b00000, 4'b1100, 0, 0, 0, Z);
      step("ml_wait",    5'b10000, 4'b0000, 0, 1, 0, e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, 0));
      step("ml_rdy_ldr", 5'b10000, 4'b0000, 0, 1, 1, e(2'b00, 2'b00, 4'b1100, 2'b01, 3'b000, 0, 0));
      step("ml_rel",     5'b00000, 4'b0000, 0, 0, 0, Z);
      step("ml_wb",      5'b00000, 4'b0000, 0, 0, 0, e(2'b00, 2'b00, 4'b0000, 2'b00, 3'b010, 0, 0));
      // timeout: one RUN detect cycle then 19 MEM_WAIT/ERROR cycles
      step("to_run",     5'b00000, 4'b0000, 0, 1, 0, e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, 0));
      for (int k = 1; k <= 19; k++)
         step($sformatf("to_wait%0d", k), 5'b00000, 4'b0000, 0, 1, 0,
              e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, (k >= 16)));
      step("err_hold1",  5'b00000, 4'b0010, 0, 0, 1, e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, 1));
      step("err_hold2",  5'b00000, 4'b0000, 0, 0, 1, e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, 1));
      do_reset();
      step("rst_err",    5'b00000, 4'b0000, 0, 0, 0, Z);
      // reset out of MEM_WAIT
      step("rw_mw_1",    5'b00000, 4'b0000, 0, 1, 0, e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, 0));
      step("rw_mw_2",    5'b00000, 4'b0000, 0, 1, 0, e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, 0));
      do_reset();
      step("rst_mw",     5'b00000, 4'b0000, 0, 0, 0, Z);
      step("run_rdy",    5'b00000, 4'b0000, 0, 1, 1, Z);
      step("run_wait",   5'b00000, 4'b0000, 0, 1, 0, e(2'b00, 2'b00, 4'b1111, 2'b00, 3'b000, 0, 0));
      step("run_back",   5'b00000, 4'b0000, 0, 1, 1, Z);
      step("run_idle",   5'b00000, 4'b0000, 0, 0, 0, Z);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
